// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a three-state handshake FSM.
// Define UART_TX_FIFO_IRQ_EN to add the registered low-watermark interrupt output tx_irq.
module uart_tx_fifo #(
    parameter int DEPTH     = 8,
    parameter int IRQ_LEVEL = 2
) (
    input  logic                   hb_clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   flush,
    input  logic                   clr_overflow,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    input  logic                   tx_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_start
`ifdef UART_TX_FIFO_IRQ_EN
    ,
    output logic                   tx_irq
`endif
);

    localparam int DATA_W = 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACCEPT,
        WAIT_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_nxt;
    logic              push;
    logic              pop;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // Full is judged on the current count, so a pop in the same cycle never rescues a push.
    assign push      = wr_en && !flush && !full;
    assign count_nxt = count + CW'(push) - CW'(pop);

    // Storage holds no reset; empty hides stale entries.
    always_ff @(posedge hb_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty && tx_ready) begin
                        pop       = 1'b1;
                        state_nxt = WAIT_ACCEPT;
                    end
                end
                WAIT_ACCEPT: begin
                    if (!tx_ready) begin
                        state_nxt = WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_start <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                tx_data <= mem[rd_ptr];
            end
            count    <= count_nxt;
            tx_start <= pop;
        end
    end

    // A dropped push beats a simultaneous clear; a write during flush is not an overflow.
    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full && !flush) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_TX_FIFO_IRQ_EN
    localparam logic [CW-1:0] IRQ_CNT = CW'(IRQ_LEVEL);

    logic pushed_since_clr;

    // Built from next-state values so tx_irq lines up with the count it describes.
    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            pushed_since_clr <= 1'b0;
            tx_irq           <= 1'b0;
        end else if (flush) begin
            pushed_since_clr <= 1'b0;
            tx_irq           <= 1'b0;
        end else begin
            if (push) begin
                pushed_since_clr <= 1'b1;
            end
            tx_irq <= (count_nxt <= IRQ_CNT) && (pushed_since_clr || push);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=8, IRQ_LEVEL=2).
module tb_uart_tx_fifo;

    logic       hb_clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       clr_overflow;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_start;
`ifdef UART_TX_FIFO_IRQ_EN
    logic       tx_irq;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    logic [7:0] st_d[$];
    int         st_c[$];

    uart_tx_fifo #(.DEPTH(8), .IRQ_LEVEL(2)) dut (
        .hb_clk       (hb_clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start)
`ifdef UART_TX_FIFO_IRQ_EN
        ,
        .tx_irq       (tx_irq)
`endif
    );

    always #5 hb_clk = ~hb_clk;

    always @(posedge hb_clk) cyc_cnt <= cyc_cnt + 1;

    // Log every load strobe with its byte and cycle number.
    always @(negedge hb_clk) begin
        if (rst_n && tx_start) begin
            st_d.push_back(tx_data);
            st_c.push_back(cyc_cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge hb_clk);
        #1;
    endtask

    // UART model: tx_ready falls one cycle after tx_start and returns 40 cycles later.
    // Pushes npush bytes base+i whenever the FIFO is not full.
    task automatic run_uart(input int ncyc, input int npush, input logic [7:0] base,
                            input bit chk_irq);
        int drop_at = -1;
        int rise_at = -1;
        int pushed  = 0;
        logic [3:0] prev_cnt = count;
        for (int c = 0; c < ncyc; c++) begin
            step();
            wr_en = 1'b0;
            if (c == drop_at) begin
                tx_ready = 1'b0;
                rise_at  = c + 40;
            end
            if (c == rise_at) tx_ready = 1'b1;
            if (tx_start) drop_at = c + 1;
            if (pushed < npush && !full) begin
                wr_en   = 1'b1;
                wr_data = base + 8'(pushed);
                pushed++;
            end
`ifdef UART_TX_FIFO_IRQ_EN
            if (chk_irq && count != prev_cnt) check_val("irq_vs_count", tx_irq, count <= 4'd2);
`endif
            prev_cnt = count;
        end
        wr_en = 1'b0;
    endtask

    initial begin
        int base;
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        flush        = 1'b0;
        clr_overflow = 1'b0;
        tx_ready     = 1'b0;
        step();
        step();
        check_val("rst_count", count, 4'd0);
        check_val("rst_empty", empty, 1'b1);
        check_val("rst_full", full, 1'b0);
        check_val("rst_overflow", overflow, 1'b0);
        check_val("rst_tx_start", tx_start, 1'b0);
        check_val("rst_tx_data", tx_data, 8'h00);
        rst_n = 1'b1;
        step();

        // Single byte latency: wr_en in cycle 0, tx_start in cycle 2.
        tx_ready = 1'b1;
        base     = st_d.size();
        wr_en    = 1'b1;
        wr_data  = 8'hA5;
        step();
        wr_en = 1'b0;
        check_val("lat_cnt1", count, 4'd1);
        check_val("lat_start_c1", tx_start, 1'b0);
        step();
        check_val("lat_start_c2", tx_start, 1'b1);
        check_val("lat_data", tx_data, 8'hA5);
        check_val("lat_cnt0", count, 4'd0);
        step();
        check_val("lat_start_c3", tx_start, 1'b0);
        check_val("lat_data_hold", tx_data, 8'hA5);
        tx_ready = 1'b0;
        step();
        tx_ready = 1'b1;
        step();
        check_val("lat_pulses", st_d.size() - base, 1);

        // Fill to full, overflow, clear priority.
        tx_ready = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            step();
        end
        check_val("fill_full", full, 1'b1);
        check_val("fill_count", count, 4'd8);
        check_val("fill_ovf0", overflow, 1'b0);
        wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        check_val("ovf_set", overflow, 1'b1);
        check_val("ovf_count", count, 4'd8);
        wr_en        = 1'b1;
        clr_overflow = 1'b1;
        step();
        wr_en = 1'b0;
        check_val("ovf_set_wins", overflow, 1'b1);
        step();
        clr_overflow = 1'b0;
        check_val("ovf_clr", overflow, 1'b0);
        base     = st_d.size();
        tx_ready = 1'b1;
        run_uart(380, 0, 8'h00, 1'b0);
        check_val("drain_pulses", st_d.size() - base, 8);
        for (int i = 0; i < 8; i++) check_val("drain_order", st_d[base + i], 8'(i));
        check_val("drain_empty", empty, 1'b1);

        // Ten bytes through the UART model, crossing pointer wrap.
        base = st_d.size();
        run_uart(480, 10, 8'h30, 1'b0);
        check_val("wrap_pulses", st_d.size() - base, 10);
        for (int i = 0; i < 10; i++) check_val("wrap_order", st_d[base + i], 8'h30 + 8'(i));
        for (int i = 1; i < 10; i++) check_val("wrap_gap", st_c[base + i] - st_c[base + i - 1], 43);
        check_val("wrap_count", count, 4'd0);
        check_val("wrap_ovf", overflow, 1'b0);

        // Flush with a simultaneous write at count=4.
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h40 + 8'(i);
            step();
        end
        check_val("fl_count4", count, 4'd4);
        wr_data = 8'hEE;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        wr_en = 1'b0;
        check_val("fl_count", count, 4'd0);
        check_val("fl_empty", empty, 1'b1);
        check_val("fl_ovf", overflow, 1'b0);
        check_val("fl_data_hold", tx_data, 8'h39);
        base     = st_d.size();
        tx_ready = 1'b1;
        step();
        step();
        step();
        check_val("fl_no_start", st_d.size() - base, 0);

        // Reset while in WAIT_DONE with three bytes queued.
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h50 + 8'(i);
            step();
        end
        wr_en    = 1'b0;
        tx_ready = 1'b0;
        step();
        check_val("wd_count3", count, 4'd3);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_count", count, 4'd0);
        check_val("mid_rst_start", tx_start, 1'b0);
        check_val("mid_rst_data", tx_data, 8'h00);
        step();
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        base     = st_d.size();
        for (int i = 0; i < 6; i++) step();
        check_val("post_rst_no_start", st_d.size() - base, 0);
        check_val("post_rst_empty", empty, 1'b1);

`ifdef UART_TX_FIFO_IRQ_EN
        check_val("irq_rst", tx_irq, 1'b0);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'h60 + 8'(i);
            step();
            if (i == 0) check_val("irq_first_push", tx_irq, 1'b1);
            if (i == 2) check_val("irq_cnt3", tx_irq, 1'b0);
        end
        wr_en = 1'b0;
        check_val("irq_cnt5", tx_irq, 1'b0);
        tx_ready = 1'b1;
        run_uart(240, 0, 8'h00, 1'b1);
        check_val("irq_drain_cnt", count, 4'd0);
        check_val("irq_drain_high", tx_irq, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
